bcd_conv_sched: RTL and testbench

- Shares one serial 12-bit-binary to 4-digit-BCD converter (BIN12_to_DEC4: `BIN`, `st`, `DEC`, no done flag) between N_CH requesters.
- Arbitrates round-robin, latches the winner's operand and pulses the converter start.
- Waits a fixed worst-case conversion window, then captures the BCD result and returns it tagged with the channel number.
- Sits between the sensor/counter front-ends and the display/UART formatting logic.

---
 rtl/bcd_conv_sched.sv | 147 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial BIN12-to-DEC4 converter between N_CH requesters.
// The converter has no done flag, so each result is captured after a fixed worst-case window.
module bcd_conv_sched #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CHW      = 2,
    parameter int unsigned WAIT_CYC = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   req,
    input  logic [12*N_CH-1:0] bin_in,
    output logic [N_CH-1:0]   ack,
    output logic [11:0]       conv_bin,
    output logic              conv_st,
    input  logic [15:0]       conv_dec,
    output logic              res_valid,
    output logic [CHW-1:0]    res_ch,
    output logic [15:0]       res_dec,
    output logic              busy
);

    localparam int unsigned CNTW = $clog2(WAIT_CYC + 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait,
        StCapture
    } state_e;

    state_e          state_q, state_d;
    logic [CHW-1:0]  rr_q, rr_d;
    logic [CHW-1:0]  cur_ch_q, cur_ch_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [11:0]     conv_bin_q, conv_bin_d;
    logic [N_CH-1:0] ack_q, ack_d;
    logic            conv_st_q, conv_st_d;
    logic            res_valid_q, res_valid_d;
    logic [CHW-1:0]  res_ch_q, res_ch_d;
    logic [15:0]     res_dec_q, res_dec_d;

    logic            hi_any, lo_any;
    logic [CHW-1:0]  hi_ch, lo_ch, win_ch;
    logic [11:0]     hi_bin, lo_bin, win_bin;

    // Lowest requester at or above rr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_ch  = '0;
        lo_ch  = '0;
        hi_bin = '0;
        lo_bin = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (req[c]) begin
                lo_any = 1'b1;
                lo_ch  = CHW'(c);
                lo_bin = bin_in[12*c +: 12];
                if (CHW'(c) >= rr_q) begin
                    hi_any = 1'b1;
                    hi_ch  = CHW'(c);
                    hi_bin = bin_in[12*c +: 12];
                end
            end
        end
        win_ch  = hi_any ? hi_ch : lo_ch;
        win_bin = hi_any ? hi_bin : lo_bin;
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cur_ch_d    = cur_ch_q;
        cnt_d       = cnt_q;
        conv_bin_d  = conv_bin_q;
        res_ch_d    = res_ch_q;
        res_dec_d   = res_dec_q;
        ack_d       = '0;
        conv_st_d   = 1'b0;
        res_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (lo_any) begin
                    conv_bin_d = win_bin;
                    cur_ch_d   = win_ch;
                    ack_d      = {{(N_CH-1){1'b0}}, 1'b1} << win_ch;
                    state_d    = StStart;
                end
            end
            StStart: begin
                conv_st_d = 1'b1;
                cnt_d     = CNTW'(WAIT_CYC - 1);
                state_d   = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                res_dec_d   = conv_dec;
                res_ch_d    = cur_ch_q;
                res_valid_d = 1'b1;
                rr_d        = (cur_ch_q == CHW'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            cur_ch_q    <= '0;
            cnt_q       <= '0;
            conv_bin_q  <= '0;
            ack_q       <= '0;
            conv_st_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_dec_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            conv_bin_q  <= conv_bin_d;
            ack_q       <= ack_d;
            conv_st_q   <= conv_st_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_dec_q   <= res_dec_d;
        end
    end

    assign ack       = ack_q;
    assign conv_bin  = conv_bin_q;
    assign conv_st   = conv_st_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_dec   = res_dec_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Randomized bench for bcd_conv_sched with a behavioural converter and a transaction-level
// scoreboard (round-robin grant order, operand snapshot, BCD result, latency, invariants).
module tb_bcd_conv_sched;

    localparam int N = 4;
    localparam int W = 80;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [12*N-1:0] bin_in;
    logic [N-1:0]    ack;
    logic [11:0]     conv_bin;
    logic            conv_st;
    logic [15:0]     conv_dec;
    logic            res_valid;
    logic [1:0]      res_ch;
    logic [15:0]     res_dec;
    logic            busy;

    bcd_conv_sched #(
        .N_CH    (N),
        .CHW     (2),
        .WAIT_CYC(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .bin_in   (bin_in),
        .ack      (ack),
        .conv_bin (conv_bin),
        .conv_st  (conv_st),
        .conv_dec (conv_dec),
        .res_valid(res_valid),
        .res_ch   (res_ch),
        .res_dec  (res_dec),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Behavioural converter: garbage on DEC while converting, correct BCD within 1..72 cycles.
    logic [11:0] cv_bin;
    int          cv_cnt;
    initial begin
        conv_dec = '0;
        cv_cnt   = 0;
        cv_bin   = '0;
    end
    always @(posedge clk) begin
        if (conv_st) begin
            cv_bin   <= conv_bin;
            cv_cnt   <= int'($urandom_range(72, 1));
            conv_dec <= 16'($urandom);
        end else if (cv_cnt != 0) begin
            cv_cnt <= cv_cnt - 1;
            if (cv_cnt == 1) conv_dec <= bcd(int'(cv_bin));
        end
    end

    logic [N-1:0]    req_s;
    logic [12*N-1:0] bin_s;
    always @(posedge clk) begin
        req_s <= req;
        bin_s <= bin_in;
    end

    typedef struct {
        int          ch;
        logic [15:0] dec;
        int          t;
    } exp_t;

    exp_t        q[$];
    int          grants[$];
    int          res_times[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_res = 0;
    int          model_rr = 0;
    logic [11:0] model_bin = '0;
    logic        pend_st = 1'b0;
    int          hold_ch = 0;
    logic [15:0] hold_dec = '0;
    logic [15:0] dut_last_dec = '0;
    int          dut_last_ch = 0;
    bit          auto_drop = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic monitor();
        int          w;
        int          s;
        logic [11:0] b;
        exp_t        e;
        cyc++;
        s = int'(|ack) + int'(conv_st) + int'(res_valid);
        check("exclusive", 32'(s <= 1), 32'd1);
        check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
        check("conv_st", 32'(conv_st), 32'(pend_st));
        pend_st = 1'b0;
        if (|ack) begin
            w = pick(req_s, model_rr);
            check("grant", 32'(ack), (w < 0) ? 32'd0 : 32'(1 << w));
            if (w >= 0) begin
                b = bin_s[12*w +: 12];
                model_bin = b;
                q.push_back('{ch: w, dec: bcd(int'(b)), t: cyc});
                grants.push_back(w);
                model_rr = (w + 1) % N;
                pend_st = 1'b1;
            end
        end
        check("conv_bin", 32'(conv_bin), 32'(model_bin));
        if (res_valid) begin
            res_times.push_back(cyc);
            dut_last_dec = res_dec;
            dut_last_ch  = int'(res_ch);
            n_res++;
            if (q.size() == 0) begin
                check("res_spurious", 32'(res_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("res_ch", 32'(res_ch), 32'(e.ch));
                check("res_dec", 32'(res_dec), 32'(e.dec));
                check("latency", 32'(cyc - e.t), 32'(W + 2));
                hold_ch  = e.ch;
                hold_dec = e.dec;
            end
        end else begin
            check("hold_dec", 32'(res_dec), 32'(hold_dec));
            check("hold_ch", 32'(res_ch), 32'(hold_ch));
        end
        check("busy", 32'(busy), 32'(q.size() != 0));
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic set_bin(input int ch, input int v);
        bin_in[12*ch +: 12] = 12'(v);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        q.delete();
        model_rr  = 0;
        model_bin = '0;
        pend_st   = 1'b0;
        hold_ch   = 0;
        hold_dec  = '0;
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_st"}, 32'(conv_st), 32'd0);
        check({tag, "_rv"}, 32'(res_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_bin"}, 32'(conv_bin), 32'd0);
        check({tag, "_ch"}, 32'(res_ch), 32'd0);
        check({tag, "_dec"}, 32'(res_dec), 32'd0);
    endtask

    task automatic wait_ack(input int ch);
        for (int k = 0; k < 400; k++) begin
            tick();
            if (ack[ch]) break;
        end
        check("ack_wait", 32'(ack[ch]), 32'd1);
    endtask

    task automatic run_until_res(input int target, input int budget);
        for (int k = 0; k < budget && n_res < target; k++) tick();
        check("res_wait", 32'(n_res >= target), 32'd1);
    endtask

    initial begin
        int g0;
        int r0;
        int a;
        int nr;
        rst_n  = 1'b0;
        req    = '0;
        bin_in = '0;
        do_reset(2);
        check_reset_outputs("reset");

        // Single channel, worst-case operand
        set_bin(2, 3999);
        req[2] = 1'b1;
        wait_ack(2);
        check("t1_ack", 32'(ack), 32'b0100);
        tick();
        check("t1_st", 32'(conv_st), 32'd1);
        check("t1_bin", 32'(conv_bin), 32'd3999);
        run_until_res(n_res + 1, 200);
        check("t1_ch", 32'(dut_last_ch), 32'd2);
        check("t1_dec", 32'(dut_last_dec), 32'h3999);

        // All four requesting from rr=0
        do_reset(1);
        set_bin(0, 0);
        set_bin(1, 7);
        set_bin(2, 1000);
        set_bin(3, 4095);
        g0 = grants.size();
        r0 = res_times.size();
        req = 4'hF;
        run_until_res(n_res + 4, 600);
        for (int k = 0; k < 4; k++) check("t2_order", 32'(grants[g0+k]), 32'(k));
        for (int k = 1; k < 4; k++)
            check("t2_spacing", 32'(res_times[r0+k] - res_times[r0+k-1]), 32'(W + 3));
        check("t2_last_dec", 32'(dut_last_dec), 32'h4095);

        // Fairness wrap: after ch1, ch3 beats ch0
        set_bin(1, 42);
        req[1] = 1'b1;
        run_until_res(n_res + 1, 200);
        g0 = grants.size();
        set_bin(0, 11);
        set_bin(3, 33);
        req = 4'b1001;
        run_until_res(n_res + 2, 400);
        check("t3_first", 32'(grants[g0]), 32'd3);
        check("t3_second", 32'(grants[g0+1]), 32'd0);

        // Operand isolation
        set_bin(1, 250);
        req[1] = 1'b1;
        wait_ack(1);
        tick();
        set_bin(1, 9);
        run_until_res(n_res + 1, 200);
        check("t4_dec", 32'(dut_last_dec), 32'h0250);

        // Reset while waiting, at counter==30
        set_bin(0, 123);
        req[0] = 1'b1;
        wait_ack(0);
        a = cyc;
        while (cyc < a + 50) tick();
        do_reset(1);
        check_reset_outputs("t5_reset");
        nr = n_res;
        repeat (120) tick();
        check("t5_no_res", 32'(n_res), 32'(nr));
        set_bin(0, 4095);
        req[0] = 1'b1;
        run_until_res(n_res + 1, 200);
        check("t5_dec", 32'(dut_last_dec), 32'h4095);
        check("t5_ch", 32'(dut_last_ch), 32'd0);

        // Random soak
        auto_drop = 1'b0;
        repeat (20000) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (ack[i] && $urandom_range(1, 0) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(15, 0) == 0) begin
                    req[i] = 1'b1;
                    set_bin(i, int'($urandom_range(4095, 0)));
                end
                if ($urandom_range(31, 0) == 0) set_bin(i, int'($urandom_range(4095, 0)));
            end
        end
        req = '0;
        for (int k = 0; k < 400 && (q.size() != 0 || busy); k++) tick();
        check("drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
